// File: rtl/enc_pkg.sv
// Shared constants, state type and encoder helper
// for the event capture / 8:3 encoder path.
package enc_pkg;
  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef enum logic {IDLE, HOLD} st_t;

  function automatic logic [CODE_W-1:0]
    onehot_to_code(input logic [N_LINES-1:0] oh);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_LINES; i++)
      if (oh[i]) c |= CODE_W'(i);
    return c;
  endfunction
endpackage

// File: rtl/event_capture_enc8_if.sv
// Valid/ready output bus carrying the selected
// event as one-hot plus binary code.
interface event_capture_enc8_if;
  import enc_pkg::*;
  logic                out_valid;
  logic                out_ready;
  logic [N_LINES-1:0]  out_onehot;
  logic [CODE_W-1:0]   out_code;

  modport master (
    output out_valid, out_onehot, out_code,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_onehot, out_code,
    output out_ready
  );
endinterface

// File: rtl/event_capture_enc8_prio_pick8.sv
// Combinational priority picker over the
// pending vector; direction set by PRIO_MSB.
module prio_pick8
  import enc_pkg::*;
#(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic [N_LINES-1:0] pending,
  output logic [N_LINES-1:0] onehot,
  output logic [CODE_W-1:0]  code,
  output logic               any
);
  always_comb begin
    onehot = '0;
    if (PRIO_MSB) begin
      for (int i = 0; i < N_LINES; i++)
        if (pending[i]) begin
          onehot    = '0;
          onehot[i] = 1'b1;
        end
    end else begin
      for (int i = N_LINES-1; i >= 0; i--)
        if (pending[i]) begin
          onehot    = '0;
          onehot[i] = 1'b1;
        end
    end
  end

  assign code = onehot_to_code(onehot);
  assign any  = |pending;
endmodule

// File: rtl/event_capture_enc8.sv
// Rising-edge capture into sticky pending bits,
// priority select into a valid/ready output stage.
module event_capture_enc8
  import enc_pkg::*;
#(
  parameter bit PRIO_MSB = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [N_LINES-1:0]  ev_in,
  event_capture_enc8_if.master bus,
  output logic [N_LINES-1:0]  pending,
  output logic [CNT_W-1:0]    drop_cnt
);
  localparam int SW = CNT_W + 4;

  logic [N_LINES-1:0] ev_q, ev_edge;
  logic [N_LINES-1:0] take_mask, drop_vec;
  logic [N_LINES-1:0] pick_oh, oh_nxt;
  logic [CODE_W-1:0]  pick_code, code_nxt;
  logic               pick_any, load;
  logic [SW-1:0]      sum;
  st_t                state, state_nxt;

  // Tracks ev_in through reset too, so lines held
  // high across reset release are not new events.
  always_ff @(posedge clk)
    ev_q <= ev_in;

  assign ev_edge = ev_in & ~ev_q;

  prio_pick8 #(.PRIO_MSB(PRIO_MSB)) u_pick (
    .pending (pending),
    .onehot  (pick_oh),
    .code    (pick_code),
    .any     (pick_any)
  );

  always_ff @(posedge clk)
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE:
        if (pick_any) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      HOLD:
        if (bus.out_ready) begin
          if (pick_any) load = 1'b1;
          else          state_nxt = IDLE;
        end
    endcase
  end

  always_comb begin
    oh_nxt   = '0;
    code_nxt = '0;
    if (load) begin
      oh_nxt   = pick_oh;
      code_nxt = pick_code;
    end else if (state_nxt == HOLD) begin
      oh_nxt   = bus.out_onehot;
      code_nxt = bus.out_code;
    end
  end

  assign take_mask = load ? pick_oh : '0;
  assign drop_vec  = ev_edge & pending & ~take_mask;
  assign bus.out_valid = (state == HOLD);

  always_ff @(posedge clk)
    if (rst || clr) begin
      bus.out_onehot <= '0;
      bus.out_code   <= '0;
    end else begin
      bus.out_onehot <= oh_nxt;
      bus.out_code   <= code_nxt;
    end

  always_ff @(posedge clk)
    if (rst || clr)
      pending <= '0;
    else
      pending <= (pending & ~take_mask) | ev_edge;

  assign sum = SW'(drop_cnt)
             + SW'($countones(drop_vec));

  always_ff @(posedge clk)
    if (rst || clr)
      drop_cnt <= '0;
    else if (|sum[SW-1:CNT_W])
      drop_cnt <= '1;
    else
      drop_cnt <= sum[CNT_W-1:0];
endmodule

// File: tb/tb_event_capture_enc8.sv
// Directed bench: one DUT per priority direction,
// shared stimulus, inline checks per scenario.
module tb_event_capture_enc8;
  logic       clk = 1'b0;
  logic       rst, clr;
  logic [7:0] ev_in;
  logic       ready;
  logic [7:0] pend1, pend0;
  logic [7:0] drop1, drop0;
  int         pass_n = 0;
  int         total_n = 0;

  event_capture_enc8_if b1 ();
  event_capture_enc8_if b0 ();
  assign b1.out_ready = ready;
  assign b0.out_ready = ready;

  event_capture_enc8 #(.PRIO_MSB(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ev_in(ev_in),
    .bus(b1), .pending(pend1), .drop_cnt(drop1)
  );
  event_capture_enc8 #(.PRIO_MSB(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .ev_in(ev_in),
    .bus(b0), .pending(pend0), .drop_cnt(drop0)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      pass_n++;
  endtask

  task automatic test_reset;
    rst = 1; clr = 0; ready = 0; ev_in = 8'hFF;
    tick(3);
    chk("rst_valid", b1.out_valid, 1'b0);
    chk("rst_onehot", b1.out_onehot, 8'h00);
    chk("rst_code", b1.out_code, 3'd0);
    chk("rst_pending", pend1, 8'h00);
    chk("rst_drop", drop1, 8'h00);
    rst = 0;
    tick(3);
    chk("rel_pending", pend1, 8'h00);
    chk("rel_valid", b1.out_valid, 1'b0);
    ev_in = 8'h00;
    tick();
  endtask

  task automatic test_single;
    ready = 1; ev_in = 8'h04;
    tick();
    chk("single_pend", pend1, 8'h04);
    chk("single_v0", b1.out_valid, 1'b0);
    ev_in = 8'h00;
    tick();
    chk("single_valid", b1.out_valid, 1'b1);
    chk("single_oh", b1.out_onehot, 8'h04);
    chk("single_code", b1.out_code, 3'd2);
    tick();
    chk("single_done", b1.out_valid, 1'b0);
    chk("single_oh0", b1.out_onehot, 8'h00);
  endtask

  task automatic test_priority;
    ready = 1; ev_in = 8'h81;
    tick();
    ev_in = 8'h00;
    tick();
    chk("msb_first", b1.out_code, 3'd7);
    chk("lsb_first", b0.out_code, 3'd0);
    chk("msb_pend", pend1, 8'h01);
    tick();
    chk("msb_second_v", b1.out_valid, 1'b1);
    chk("msb_second", b1.out_code, 3'd0);
    chk("lsb_second", b0.out_code, 3'd7);
    chk("lsb_second_oh", b0.out_onehot, 8'h80);
    tick();
    chk("prio_idle", b1.out_valid, 1'b0);
  endtask

  task automatic test_backpressure;
    ready = 0; ev_in = 8'h08;
    tick();
    ev_in = 8'h00;
    tick();
    ev_in = 8'h20;
    tick();
    ev_in = 8'h00;
    tick(2);
    chk("bp_valid", b1.out_valid, 1'b1);
    chk("bp_code", b1.out_code, 3'd3);
    chk("bp_oh", b1.out_onehot, 8'h08);
    chk("bp_pend", pend1, 8'h20);
    ready = 1;
    tick();
    chk("bp_next", b1.out_code, 3'd5);
    chk("bp_next_v", b1.out_valid, 1'b1);
    chk("bp_pend0", pend1, 8'h00);
    tick();
    chk("bp_idle", b1.out_valid, 1'b0);
    chk("bp_code0", b1.out_code, 3'd0);
  endtask

  task automatic test_multi_drop;
    clr = 1; tick(); clr = 0;
    ready = 0; ev_in = 8'h01;
    tick();
    ev_in = 8'h00;
    tick();
    ev_in = 8'h0E;
    tick();
    ev_in = 8'h00;
    tick();
    ev_in = 8'h0E;
    tick();
    chk("mdrop_cnt", drop1, 8'd3);
    chk("mdrop_pend", pend1, 8'h0E);
    ev_in = 8'h00;
    tick();
  endtask

  task automatic test_saturation;
    clr = 1; tick(); clr = 0;
    ready = 0; ev_in = 8'h01;
    tick();
    ev_in = 8'h00;
    tick();
    ev_in = 8'h02;
    tick();
    chk("sat_pend", pend1, 8'h02);
    for (int i = 0; i < 300; i++) begin
      ev_in = 8'h00;
      tick();
      ev_in = 8'h02;
      tick();
      if (i == 9) chk("sat_mid", drop1, 8'd10);
    end
    chk("sat_cnt", drop1, 8'hFF);
    chk("sat_hold", b1.out_code, 3'd0);
    ev_in = 8'h00;
    tick();
  endtask

  task automatic test_load_clr;
    clr = 1; tick(); clr = 0;
    ready = 0; ev_in = 8'h01;
    tick();
    ev_in = 8'h00;
    tick();
    ev_in = 8'h04;
    tick();
    ev_in = 8'h00;
    tick();
    ready = 1; ev_in = 8'h04;
    tick();
    chk("eol_code", b1.out_code, 3'd2);
    chk("eol_pend", pend1, 8'h04);
    chk("eol_drop", drop1, 8'd0);
    ready = 0; ev_in = 8'h00;
    tick();
    ev_in = 8'h04;
    tick();
    chk("eol_drop1", drop1, 8'd1);
    ev_in = 8'h00;
    tick();
    clr = 1; ev_in = 8'h40;
    tick();
    chk("clr_pend", pend1, 8'h00);
    chk("clr_valid", b1.out_valid, 1'b0);
    chk("clr_oh", b1.out_onehot, 8'h00);
    chk("clr_drop", drop1, 8'd0);
    clr = 0;
    tick(2);
    chk("clr_edge_gone", pend1, 8'h00);
    chk("clr_still_idle", b1.out_valid, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_multi_drop();
    test_saturation();
    test_load_clr();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
